conv_loop_sequencer: RTL
========================

# conv_loop_sequencer

Generates the convolution loop nest that drives the address-generating conv controller: output channel, output row `r`, output column `c`, kernel row `i`, kernel column `j`. It accepts a start/stall handshake from the layer top and emits per-tap MAC qualifiers (clear, valid, last). It also emits an output-buffer write strobe aligned to the controller's delayed output address. It sits between the layer top and the controller, which consumes `r/c/i/j` combinationally on its registered address path.

## Interface
- `out_size`, default 2: output feature map width and height; legal range 1..16.
- `k`, default 3: kernel width and height; legal range 1..16.
- `out_channel`, default 1: number of output channels iterated; legal range 1..4.
- `wb_lat`, default 10: cycles from a tap's `mac_valid` to its write-back slot (address register plus 9-deep delay line); legal range 1..15.

Ports:
- `clock`, in, 1: single clock; all logic is rising-edge.
- `rst_n`, in, 1: reset; asynchronous, active-low.
- `start`, in, 1: layer start request; sampled in IDLE only.
- `stall`, in, 1: freezes iteration for the current cycle.
- `busy`, out, 1: high from start acceptance until `done`.
- `done`, out, 1: one-cycle pulse after the final write-back.
- `r`, `c`, `i`, `j`, out, 4 each: loop iterators.
- `out_chan_idx`, out, 2: current output channel.
- `mac_valid`, out, 1: the current `r/c/i/j` is a live tap.
- `acc_clr`, out, 1: first tap of a window (`i==0 && j==0`), qualified by `mac_valid`.
- `acc_last`, out, 1: last tap of a window (`i==k-1 && j==k-1`), qualified by `mac_valid`.
- `out_we`, out, 1: `acc_last` delayed exactly `wb_lat` cycles.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- **IDLE**
  - Outputs are at reset values.
  - `start==1` → RUN; iterators load 0.
- **RUN**
  - Each cycle with `stall==0`: `mac_valid=1`, and the iterators advance odometer-style: `j`, then `i`, then `c`, then `r`, then `out_chan_idx`.
  - Each iterator wraps at its limit (`k-1`, `k-1`, `out_size-1`, `out_size-1`, `out_channel-1`) and carries into the next.
  - Terminal tap: all iterators at their limits. When it is issued unstalled, the FSM moves to DRAIN and the iterators return to 0.
- **Stall**: with `stall==1` in RUN, the iterators hold and `mac_valid`, `acc_clr` and `acc_last` are 0. The write-back delay line keeps shifting regardless of stall.
- **DRAIN**
  - A 4-bit counter loads `wb_lat-1` on entry and decrements every cycle; `stall` is ignored.
  - Counter at 0 → DONE.
- **DONE**
  - `done=1` and `busy=0` for one cycle, then IDLE.
- `start` outside IDLE is ignored; the request is not queued.
- `out_we`: a `wb_lat`-deep shift register fed by `acc_last`. It clears on reset only, so it is not flushed at state changes.
- Reset mid-operation: all state returns to IDLE immediately and the delay line clears, so no `out_we` fires after reset.
- Degenerate case `k==1`: `acc_clr` and `acc_last` are both high on every valid tap.

## Timing
- Reset values:
  - `busy`, `done`, `mac_valid`, `acc_clr`, `acc_last`, `out_we` = 0.
  - `r`, `c`, `i`, `j`, `out_chan_idx` = 0.
- All outputs are registered.
- `start` sampled at edge E → `busy=1`, `mac_valid=1` and `r/c/i/j=0` appear after E. That is the first tap, cycle 1.
- Total unstalled MAC cycles: `out_channel*out_size²*k²`; the default is 36.
- Each stall cycle extends the run by exactly one cycle.
- Write-back: the window whose last tap is at cycle T gets `out_we` at cycle T+`wb_lat`.
- The final `out_we` coincides with the last DRAIN cycle; `done` follows one cycle later.
- Defaults: `done` at cycle 36+10+1 = 47.

## Configuration
- Macro `CONV_SEQ_STALL_CNT_EN`.
- **Defined**: adds output port `stall_cnt` [15:0].
  - Cleared on reset and on start acceptance.
  - Increments on every RUN cycle with `stall==1`; saturates at 0xFFFF.
  - Holds its value after `done`.
- **Undefined**: the port and the counter are absent; all other behaviour is identical.

## Test plan
- **Default run, no stall**: pulse `start` → 36 `mac_valid` cycles; `acc_clr` at cycles 1, 10, 19, 28; `acc_last` at 9, 18, 27, 36; `out_we` at 19, 28, 37, 46; `done` at 47; `busy` low at 47.
- **Iterator order**: check (r,c,i,j) at cycle 1 = (0,0,0,0), cycle 4 = (0,0,1,0), cycle 10 = (0,1,0,0) and cycle 19 = (1,0,0,0).
- **Stall**: hold `stall=1` for 3 cycles starting at cycle 5 → iterators frozen at (0,0,1,1) and `mac_valid=0` during those cycles; `done` at 50; with `CONV_SEQ_STALL_CNT_EN`, `stall_cnt==3`.
- **Start while busy**: pulse `start` again at cycle 20 → no restart; `done` still at 47; a second `start` issued after `done` runs normally.
- **Reset mid-run**: assert `rst_n=0` at cycle 25 → all outputs 0 asynchronously; no `out_we` after reset; a fresh `start` gives `done` 47 cycles later.
- **Parameters `out_channel=4`, `k=1`, `out_size=2`**: 16 taps, each with `acc_clr=acc_last=1`; `out_chan_idx` steps 0→3 every 4 taps; `done` at cycle 27.

Source files
------------

// File: rtl/conv_loop_sequencer_if.sv
// Layer-top <-> conv loop sequencer handshake and tap qualifier bundle.
// Optional stall_cnt member present only when CONV_SEQ_STALL_CNT_EN is defined.
interface conv_loop_sequencer_if;
  logic       start;
  logic       stall;
  logic       busy;
  logic       done;
  logic [3:0] r;
  logic [3:0] c;
  logic [3:0] i;
  logic [3:0] j;
  logic [1:0] out_chan_idx;
  logic       mac_valid;
  logic       acc_clr;
  logic       acc_last;
  logic       out_we;
`ifdef CONV_SEQ_STALL_CNT_EN
  logic [15:0] stall_cnt;

  modport master (
    output start, stall,
    input  busy, done, r, c, i, j, out_chan_idx,
    input  mac_valid, acc_clr, acc_last, out_we, stall_cnt
  );
  modport slave (
    input  start, stall,
    output busy, done, r, c, i, j, out_chan_idx,
    output mac_valid, acc_clr, acc_last, out_we, stall_cnt
  );
`else
  modport master (
    output start, stall,
    input  busy, done, r, c, i, j, out_chan_idx,
    input  mac_valid, acc_clr, acc_last, out_we
  );
  modport slave (
    input  start, stall,
    output busy, done, r, c, i, j, out_chan_idx,
    output mac_valid, acc_clr, acc_last, out_we
  );
`endif
endinterface

// File: rtl/conv_loop_sequencer.sv
// Convolution loop-nest sequencer: walks (chan, r, c, i, j) odometer-style and emits MAC qualifiers
// plus a write strobe delayed wb_lat cycles. Optional stall counter under CONV_SEQ_STALL_CNT_EN.
module conv_loop_sequencer #(
  parameter int unsigned out_size    = 2,
  parameter int unsigned k           = 3,
  parameter int unsigned out_channel = 1,
  parameter int unsigned wb_lat      = 10
) (
  input  logic                  clock,
  input  logic                  rst_n,
  conv_loop_sequencer_if.slave  bus
);

  localparam logic [3:0] K_LAST  = 4'(k - 1);
  localparam logic [3:0] OS_LAST = 4'(out_size - 1);
  localparam logic [1:0] OC_LAST = 2'(out_channel - 1);
  localparam logic [3:0] WB_INIT = 4'(wb_lat - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [3:0]        r_q, r_d, c_q, c_d, i_q, i_d, j_q, j_d;
  logic [1:0]        ch_q, ch_d;
  logic              mac_valid_q, mac_valid_d;
  logic              clr_q, clr_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [3:0]        drain_q, drain_d;
  logic [wb_lat-1:0] wb_q, wb_d;
  logic [wb_lat:0]   wb_ext;
  logic              terminal;

  assign terminal = (j_q == K_LAST) && (i_q == K_LAST) && (c_q == OS_LAST) &&
                    (r_q == OS_LAST) && (ch_q == OC_LAST);

  // Qualifiers are computed from next-state values so every output leaves a flop.
  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    c_d         = c_q;
    i_d         = i_q;
    j_d         = j_q;
    ch_d        = ch_q;
    mac_valid_d = 1'b0;
    drain_d     = drain_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d     = S_RUN;
          r_d         = '0;
          c_d         = '0;
          i_d         = '0;
          j_d         = '0;
          ch_d        = '0;
          mac_valid_d = 1'b1;
        end
      end
      S_RUN: begin
        if (!bus.stall) begin
          if (terminal) begin
            state_d = S_DRAIN;
            r_d     = '0;
            c_d     = '0;
            i_d     = '0;
            j_d     = '0;
            ch_d    = '0;
            drain_d = WB_INIT;
          end else begin
            mac_valid_d = 1'b1;
            if (j_q != K_LAST) begin
              j_d = j_q + 4'd1;
            end else begin
              j_d = '0;
              if (i_q != K_LAST) begin
                i_d = i_q + 4'd1;
              end else begin
                i_d = '0;
                if (c_q != OS_LAST) begin
                  c_d = c_q + 4'd1;
                end else begin
                  c_d = '0;
                  if (r_q != OS_LAST) begin
                    r_d = r_q + 4'd1;
                  end else begin
                    r_d  = '0;
                    ch_d = ch_q + 2'd1;
                  end
                end
              end
            end
          end
        end
      end
      S_DRAIN: begin
        if (drain_q == '0) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    clr_d  = mac_valid_d && (i_d == '0) && (j_d == '0);
    last_d = mac_valid_d && (i_d == K_LAST) && (j_d == K_LAST);
    busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
    wb_ext = {wb_q, last_q};
    wb_d   = wb_ext[wb_lat-1:0];
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      r_q         <= '0;
      c_q         <= '0;
      i_q         <= '0;
      j_q         <= '0;
      ch_q        <= '0;
      mac_valid_q <= 1'b0;
      clr_q       <= 1'b0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      drain_q     <= '0;
      wb_q        <= '0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      c_q         <= c_d;
      i_q         <= i_d;
      j_q         <= j_d;
      ch_q        <= ch_d;
      mac_valid_q <= mac_valid_d;
      clr_q       <= clr_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      drain_q     <= drain_d;
      wb_q        <= wb_d;
    end
  end

`ifdef CONV_SEQ_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if ((state_q == S_IDLE) && bus.start) begin
      stall_cnt_q <= '0;
    end else if ((state_q == S_RUN) && bus.stall && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
`endif

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.r            = r_q;
  assign bus.c            = c_q;
  assign bus.i            = i_q;
  assign bus.j            = j_q;
  assign bus.out_chan_idx = ch_q;
  assign bus.mac_valid    = mac_valid_q;
  assign bus.acc_clr      = clr_q;
  assign bus.acc_last     = last_q;
  assign bus.out_we       = wb_q[wb_lat-1];

endmodule
